// File: rtl/audio_fx_proc.sv
// audio_fx_proc: echo effect processor (passthrough, feed-forward, feedback) with a delay-line RAM.
// Define AUDIO_FX_SAT_EN to saturate the echo sum instead of wrapping it.
module audio_fx_proc #(
   parameter int DW = 10,
   parameter int DEPTH_LOG2 = 13
) (
   input  logic                  sysclk,
   input  logic                  rst_n,
   input  logic [DW-1:0]         data_in,
   input  logic                  data_valid,
   input  logic [1:0]            mode,
   input  logic [DEPTH_LOG2-1:0] delay_len,
   input  logic [1:0]            gain_sel,
   output logic [DW-1:0]         data_out,
   output logic                  out_valid,
   output logic                  busy,
   output logic                  ovf
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   typedef enum logic [2:0] {IDLE, READ, WAIT, CALC, WRITE} state_t;
   state_t state, nxt;
   logic [DW-1:0] mem [DEPTH];
   logic signed [DW-1:0] xs, rd_q, d, y_sum, y_c, w_c, wdata;
   logic signed [DW:0] xs_ext, d_ext, sum;
   logic [1:0] mode_q, gain_q;
   logic [DEPTH_LOG2-1:0] dly_q, wr_ptr;
   logic [DEPTH_LOG2:0] fill;

   assign busy = state != IDLE;

   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE:    nxt = data_valid ? READ : IDLE;
         READ:    nxt = WAIT;
         WAIT:    nxt = CALC;
         CALC:    nxt = WRITE;
         default: nxt = IDLE;
      endcase
   end

   // Delayed term only counts once that many samples have been written since reset.
   always_comb begin
      d = (dly_q == '0 || {1'b0, dly_q} > fill) ? '0 : rd_q;
      d_ext = {d[DW-1], d};
      xs_ext = {xs[DW-1], xs};
      sum = xs_ext + (d_ext >>> ({1'b0, gain_q} + 3'd1));
`ifdef AUDIO_FX_SAT_EN
      y_sum = (sum[DW] != sum[DW-1]) ? (sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}}) : sum[DW-1:0];
`else
      y_sum = sum[DW-1:0];
`endif
      y_c = (mode_q == 2'd1 || mode_q == 2'd2) ? y_sum : xs;
      w_c = (mode_q == 2'd2) ? y_c : xs;
   end

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state <= IDLE;
         data_out <= {1'b1, {(DW-1){1'b0}}};
         out_valid <= 1'b0;
         ovf <= 1'b0;
         wr_ptr <= '0;
         fill <= '0;
      end else begin
         state <= nxt;
         out_valid <= state == CALC;
         if (data_valid && state != IDLE) ovf <= 1'b1;
         if (data_valid && state == IDLE) begin
            xs <= {~data_in[DW-1], data_in[DW-2:0]};
            mode_q <= mode;
            dly_q <= delay_len;
            gain_q <= gain_sel;
         end
         if (state == CALC) begin
            data_out <= {~y_c[DW-1], y_c[DW-2:0]};
            wdata <= w_c;
         end
         if (state == WRITE) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (!fill[DEPTH_LOG2]) fill <= fill + 1'b1;
         end
      end
   end

   // RAM is never cleared; a write is suppressed only by reset in the same edge.
   always_ff @(posedge sysclk) begin
      if (state == READ) rd_q <= mem[wr_ptr - dly_q];
      if (rst_n && state == WRITE) mem[wr_ptr] <= wdata;
   end
endmodule

// File: tb/tb_audio_fx_proc.sv
// tb_audio_fx_proc: directed and random checks of audio_fx_proc against an integer reference model.
module tb_audio_fx_proc;
   logic sysclk = 1'b0;
   logic rst_n;
   logic [9:0] data_in;
   logic data_valid;
   logic [1:0] mode;
   logic [3:0] delay_len;
   logic [1:0] gain_sel;
   logic [9:0] data_out;
   logic out_valid, busy, ovf;

   int vectors = 0;
   int errors = 0;
   int mem_m[16];
   int wp = 0;
   int fc = 0;
   int last = 512;

   audio_fx_proc #(.DW(10), .DEPTH_LOG2(4)) dut (
      .sysclk(sysclk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
      .mode(mode), .delay_len(delay_len), .gain_sel(gain_sel),
      .data_out(data_out), .out_valid(out_valid), .busy(busy), .ovf(ovf)
   );

   always #5 sysclk = ~sysclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model_step(input int din, input int m, input int dl, input int g);
      int xs, dd, s, ys, y;
      xs = din - 512;
      dd = (dl == 0 || dl > fc) ? 0 : mem_m[(wp - dl) & 15];
      s = xs + (dd >>> (g + 1));
`ifdef AUDIO_FX_SAT_EN
      ys = s > 511 ? 511 : (s < -512 ? -512 : s);
`else
      ys = ((s + 512) & 1023) - 512;
`endif
      y = (m == 1 || m == 2) ? ys : xs;
      mem_m[wp] = (m == 2) ? y : xs;
      wp = (wp + 1) & 15;
      if (fc < 16) fc++;
      return y + 512;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge sysclk);
      chk("rst_dout", data_out, 512);
      chk("rst_ov", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      wp = 0;
      fc = 0;
      last = 512;
   endtask

   task automatic send(input int din, input int m, input int dl, input int g, input int req);
      int e;
      e = model_step(din, m, dl, g);
      if (req >= 0) e = req;
      data_in = din[9:0]; mode = m[1:0]; delay_len = dl[3:0]; gain_sel = g[1:0]; data_valid = 1'b1;
      @(negedge sysclk);
      data_valid = 1'b0;
      data_in = 10'($urandom); mode = 2'($urandom); delay_len = 4'($urandom); gain_sel = 2'($urandom);
      chk("busy", busy, 1);
      @(negedge sysclk);
      chk("early_ov", out_valid, 0);
      @(negedge sysclk);
      chk("early_ov", out_valid, 0);
      chk("hold_dout", data_out, last);
      @(negedge sysclk);
      chk("ov", out_valid, 1);
      chk("dout", data_out, e);
      @(negedge sysclk);
      chk("ov_pulse", out_valid, 0);
      last = e;
      repeat (5) @(negedge sysclk);
   endtask

   initial begin
      int e, cnt, got;
      rst_n = 1'b0; data_valid = 1'b0; data_in = '0; mode = '0; delay_len = '0; gain_sel = '0;
      repeat (2) @(negedge sysclk);
      do_reset();
      send(700, 0, 0, 0, 700);
      do_reset();
      send(612, 1, 3, 0, 612);
      send(512, 1, 3, 0, 512);
      send(512, 1, 3, 0, 512);
      send(512, 1, 3, 0, 562);
      do_reset();
      send(612, 2, 2, 0, 612);
      send(512, 2, 2, 0, 512);
      send(512, 2, 2, 0, 562);
      send(512, 2, 2, 0, 512);
      send(512, 2, 2, 0, 537);
      send(512, 2, 2, 0, 512);
      do_reset();
      send(1023, 1, 1, 0, 1023);
`ifdef AUDIO_FX_SAT_EN
      send(1023, 1, 1, 0, 1023);
`else
      send(1023, 1, 1, 0, 254);
`endif
      do_reset();
      send(612, 1, 5, 0, 612);
      e = model_step(612, 0, 0, 0);
      data_in = 10'd612; mode = 2'd0; delay_len = 4'd0; gain_sel = 2'd0; data_valid = 1'b1;
      @(negedge sysclk);
      data_in = 10'd300;
      @(negedge sysclk);
      data_valid = 1'b0;
      cnt = 0;
      got = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge sysclk);
         if (out_valid) begin cnt++; got = int'(data_out); end
      end
      chk("dbl_cnt", cnt, 1);
      chk("dbl_dout", got, e);
      chk("dbl_ovf", ovf, 1);
      last = e;
      send(512, 0, 0, 0, -1);
      chk("ovf_sticky", ovf, 1);
      do_reset();
      send(900, 0, 0, 0, 900);
      data_in = 10'd800; mode = 2'd1; delay_len = 4'd0; gain_sel = 2'd0; data_valid = 1'b1;
      @(negedge sysclk);
      data_valid = 1'b0;
      repeat (2) @(negedge sysclk);
      chk("calc_busy", busy, 1);
      rst_n = 1'b0;
      @(negedge sysclk);
      chk("abort_ov", out_valid, 0);
      chk("abort_dout", data_out, 512);
      chk("abort_busy", busy, 0);
      rst_n = 1'b1;
      wp = 0; fc = 0; last = 512;
      cnt = 0;
      repeat (6) begin
         @(negedge sysclk);
         if (out_valid) cnt++;
      end
      chk("abort_no_ov", cnt, 0);
      do_reset();
      for (int i = 0; i < 80; i++)
         send(int'($urandom_range(1023)), int'($urandom_range(3)), int'($urandom_range(15)), int'($urandom_range(3)), -1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/audio_fx_proc.md
AUDIO_FX_PROC -- requirements
Module: audio_fx_proc

Interface
REQ-001 Parameter DW, default 10: sample width in bits, offset-binary, matching the ADC/DAC path.
REQ-002 Parameter DEPTH_LOG2, default 13: delay-line address width; depth = 2^DEPTH_LOG2 samples.
REQ-003 sysclk  in  1  system clock (50 MHz); all state SHALL change only on its rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 data_in  in  DW  sample from spi2adc, offset binary (midscale 2^(DW-1)).
REQ-006 data_valid  in  1  single-cycle strobe; data_in is valid in that cycle.
REQ-007 mode  in  2  0=passthrough, 1=feed-forward echo, 2=feedback echo, 3=passthrough.
REQ-008 delay_len  in  DEPTH_LOG2  echo delay in samples; 0 means echo disabled.
REQ-009 gain_sel  in  2  echo attenuation; delayed term is arithmetically right-shifted by gain_sel+1.
REQ-010 data_out  out  DW  processed sample to spi2dac, offset binary, registered.
REQ-011 out_valid  out  1  single-cycle strobe when data_out updates.
REQ-012 busy  out  1  high whenever the FSM is not in IDLE.
REQ-013 ovf  out  1  sticky flag; set when a sample is dropped.

Function
REQ-014 FSM states: IDLE, READ, WAIT, CALC, WRITE; IDLE->READ on data_valid; READ->WAIT->CALC->WRITE->IDLE unconditionally.
REQ-015 On data_valid in IDLE: capture data_in, mode, delay_len and gain_sel; later input changes do not affect that sample.
REQ-016 data_valid while not in IDLE: drop the sample and set ovf; the FSM is not disturbed.
REQ-017 Latency: out_valid is high exactly 4 cycles after the data_valid cycle, for 1 cycle; data_out updates in that same cycle.
REQ-018 Signed conversion: xs = data_in with MSB inverted (two's complement, DW bits); output = result with MSB inverted.
REQ-019 Delay RAM: single-port-per-operation, depth 2^DEPTH_LOG2 x DW, read latency 1 (READ issues address, WAIT absorbs latency).
REQ-020 Read address = wr_ptr - delay_len, modulo 2^DEPTH_LOG2; wr_ptr increments by 1 in WRITE and wraps from 2^DEPTH_LOG2-1 to 0.
REQ-021 Fill counter counts writes since reset and saturates at 2^DEPTH_LOG2; if delay_len = 0 or delay_len > fill count, the delayed term d = 0.
REQ-022 CALC: sum = xs + (d >>> (gain_sel+1)), computed in DW+1 bits.
REQ-023 Mode 0/3: y = xs and the RAM stores xs. Mode 1: y = sum and the RAM stores xs. Mode 2: y = sum and the RAM stores y.
REQ-024 A RAM write occurs once per accepted sample in WRITE, in all modes.
REQ-025 A mode or delay_len change takes effect on the next accepted sample; RAM contents and fill count are retained.

Reset
REQ-026 rst_n low at a clock edge: FSM->IDLE, data_out = 2^(DW-1), out_valid = 0, busy = 0, ovf = 0, wr_ptr = 0, fill count = 0.
REQ-027 Reset mid-operation aborts the in-flight sample: no out_valid, and no RAM write after that edge. RAM contents are not cleared.

Configuration
REQ-028 Macro AUDIO_FX_SAT_EN defined: sum saturates to [-2^(DW-1), 2^(DW-1)-1].
REQ-029 Macro AUDIO_FX_SAT_EN undefined: sum is truncated to its low DW bits (two's complement wrap).

Verification (DW=10, DEPTH_LOG2=4, gain_sel=0 unless stated)
REQ-030 Reset, then mode 0 with a data_valid pulse and data_in=700 -> out_valid 4 cycles later, data_out=700; data_out=512 before that.
REQ-031 Mode 1, delay_len=3; samples 612,512,512,512 (spaced 10 cycles) -> outputs 612,512,512,562.
REQ-032 Mode 2, delay_len=2; samples 612 then five at 512 -> outputs 612,512,562,512,537,512.
REQ-033 Mode 1, delay_len=1; samples 1023,1023 -> second output 1023 with the macro; 254 without it.
REQ-034 data_valid on two consecutive cycles -> exactly one out_valid, ovf=1, and ovf stays 1 until reset.
REQ-035 Fill/reset: after reset, mode 1 with delay_len=5 and first sample 612 -> output 612. Separately, rst_n low during CALC -> no out_valid, and data_out=512 on the next cycle.
